// File: rtl/clusterv_sram_2p_arb_if.sv
// Single requester port of the clusterv two-port main SRAM.
// The master drives the request fields. The slave (the SRAM) returns the
// combinational ack and the registered read response.
interface clusterv_sram_2p_arb_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) ();
    localparam int BE_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  read_en;
    logic                  write_en;
    logic [BE_W-1:0]       byte_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  ack;
    logic                  read_valid;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output addr, read_en, write_en, byte_en, write_data,
        input  ack, read_valid, read_data
    );

    modport slave (
        input  addr, read_en, write_en, byte_en, write_data,
        output ack, read_valid, read_data
    );
endinterface

// File: rtl/clusterv_sram_2p_arb.sv
// clusterv_sram_2p_arb: byte-enabled single-ported flop SRAM.
// Two requesters share the array through a round-robin arbiter. An access
// is granted combinationally and the read data is registered one cycle later.
//
// Optional feature: define CLUSTERV_SRAM_INIT_CLEAR_EN to build the
// post-reset clear sequencer. The sequencer zeroes words 0..DEPTH-1, one
// per cycle, before ready rises. Without the macro the array accepts
// requests straight out of reset, and its contents stay X until written.
module clusterv_sram_2p_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    ready,
    clusterv_sram_2p_arb_if.slave   t0,
    clusterv_sram_2p_arb_if.slave   t1
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IW-1:0]       CLR_LAST = IW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef CLUSTERV_SRAM_INIT_CLEAR_EN
    localparam state_t RESET_STATE = ST_INIT;
    localparam logic   RESET_READY = 1'b0;
`else
    localparam state_t RESET_STATE = ST_RUN;
    localparam logic   RESET_READY = 1'b1;
`endif

    // Replace the enabled byte lanes of old_word with the new data.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_W-1:0]       lanes
    );
        logic [DATA_WIDTH-1:0] merged;
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = lanes[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    state_t                state_r;
    logic                  ready_r;
    logic [IW-1:0]         clr_cnt_r;
    logic                  last_grant_r;   // 0: port 0 granted last, 1: port 1
    logic                  rd_valid0_r;
    logic                  rd_valid1_r;
    logic [DATA_WIDTH-1:0] rd_data0_r;
    logic [DATA_WIDTH-1:0] rd_data1_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  req0_s;
    logic                  req1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  sel_wr_s;
    logic [BE_W-1:0]       sel_be_s;
    logic [DATA_WIDTH-1:0] sel_wd_s;
    logic                  in_range_s;
    logic [IW-1:0]         idx_s;
    logic [DATA_WIDTH-1:0] old_word_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  wr_fire_s;
    logic                  clear_we_s;

    // Round-robin arbitration: on contention the port not granted last wins.
    // Reset also gates the grant, so ack is 0 for as long as reset is held.
    always_comb begin
        req0_s = t0.read_en | t0.write_en;
        req1_s = t1.read_en | t1.write_en;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (ready_r && reset) begin
            if (req0_s && (!req1_s || last_grant_r)) begin
                gnt0_s = 1'b1;
            end else if (req1_s) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Steer the granted port onto the array and build the write/read words.
    always_comb begin
        if (gnt1_s) begin
            sel_addr_s = t1.addr;
            sel_wr_s   = t1.write_en;
            sel_be_s   = t1.byte_en;
            sel_wd_s   = t1.write_data;
        end else begin
            sel_addr_s = t0.addr;
            sel_wr_s   = t0.write_en;
            sel_be_s   = t0.byte_en;
            sel_wd_s   = t0.write_data;
        end
        in_range_s = ({1'b0, sel_addr_s} < DEPTH_X);
        idx_s      = sel_addr_s[IW-1:0];
        old_word_s = mem_r[idx_s];
        merged_s   = merge_lanes(old_word_s, sel_wd_s, sel_be_s);
        if (!in_range_s) begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end else if (sel_wr_s) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = old_word_s;
        end
        wr_fire_s  = (gnt0_s | gnt1_s) & sel_wr_s & in_range_s;
        clear_we_s = (state_r == ST_INIT);
    end

    // Storage array (no reset): receives clear writes in INIT, granted writes in RUN.
    always_ff @(posedge clock) begin
        if (clear_we_s) begin
            mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
        end else if (wr_fire_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Init/run sequencer: walk the clear counter through every word, then open the array.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= RESET_STATE;
            ready_r   <= RESET_READY;
            clr_cnt_r <= {IW{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    ready_r <= 1'b0;
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r   <= ST_RUN;
                        ready_r   <= 1'b1;
                        clr_cnt_r <= {IW{1'b0}};
                    end else begin
                        clr_cnt_r <= clr_cnt_r + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= RESET_STATE;
                    ready_r   <= RESET_READY;
                    clr_cnt_r <= {IW{1'b0}};
                end
            endcase
        end
    end

    // Grant history and per-port registered read response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_r <= 1'b1;
            rd_valid0_r  <= 1'b0;
            rd_valid1_r  <= 1'b0;
            rd_data0_r   <= {DATA_WIDTH{1'b0}};
            rd_data1_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            if (gnt0_s) begin
                last_grant_r <= 1'b0;
            end else if (gnt1_s) begin
                last_grant_r <= 1'b1;
            end
            rd_valid0_r <= gnt0_s & t0.read_en;
            rd_valid1_r <= gnt1_s & t1.read_en;
            if (gnt0_s && t0.read_en) begin
                rd_data0_r <= rd_word_s;
            end
            if (gnt1_s && t1.read_en) begin
                rd_data1_r <= rd_word_s;
            end
        end
    end

    assign ready         = ready_r;
    assign t0.ack        = gnt0_s;
    assign t1.ack        = gnt1_s;
    assign t0.read_valid = rd_valid0_r;
    assign t1.read_valid = rd_valid1_r;
    assign t0.read_data  = rd_data0_r;
    assign t1.read_data  = rd_data1_r;
endmodule

// File: tb/tb_clusterv_sram_2p_arb.sv
// Self-checking bench for clusterv_sram_2p_arb (DEPTH=64, 32-bit words).
// A negedge monitor does the following each cycle:
// - predicts arbitration,
// - keeps a reference memory,
// - pushes expected read words into per-port queues,
// - pops and compares each queue when that port's read_valid is expected.
module tb_clusterv_sram_2p_arb;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int DEP = 64;
`ifdef CLUSTERV_SRAM_INIT_CLEAR_EN
    localparam int   CLR_CYC = DEP;
    localparam logic RST_RDY = 1'b0;
`else
    localparam int   CLR_CYC = 0;
    localparam logic RST_RDY = 1'b1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ready;

    clusterv_sram_2p_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) t0_if ();
    clusterv_sram_2p_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) t1_if ();

    clusterv_sram_2p_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clock (clock),
        .reset (reset),
        .ready (ready),
        .t0    (t0_if),
        .t1    (t1_if)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] mdl [DEP];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        lg;
    logic        rv0_e;
    logic        rv1_e;
    logic [31:0] last_rd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference access: updates mdl and returns the word a read would see.
    task automatic model_access(input logic wr, input logic [AW-1:0] a, input logic [3:0] be,
                                input logic [31:0] wd, output logic [31:0] val);
        logic [31:0] mask;
        logic [31:0] nw;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
        if (a >= AW'(DEP)) begin
            val = 32'h0;
        end else begin
            nw = wr ? ((mdl[a] & ~mask) | (wd & mask)) : mdl[a];
            mdl[a] = nw;
            val = nw;
        end
    endtask

    // Count rising edges since reset release.
    initial forever begin
        @(posedge clock);
        cyc = reset ? cyc + 1 : 0;
    end

    // Monitor / scoreboard.
    initial begin
        logic        rdy_e, r0, r1, g0, g1;
        logic [31:0] v;
        forever begin
            @(negedge clock);
            if (!reset) begin
                lg = 1'b1; rv0_e = 1'b0; rv1_e = 1'b0;
                q0.delete(); q1.delete();
`ifdef CLUSTERV_SRAM_INIT_CLEAR_EN
                for (int i = 0; i < DEP; i++) mdl[i] = 32'h0;
`endif
            end else begin
                rdy_e = (cyc >= CLR_CYC);
                r0 = t0_if.read_en | t0_if.write_en;
                r1 = t1_if.read_en | t1_if.write_en;
                g0 = rdy_e && r0 && (!r1 || lg);
                g1 = rdy_e && r1 && !g0;
                check_eq("ready", 32'(ready), 32'(rdy_e));
                check_eq("t0_ack", 32'(t0_if.ack), 32'(g0));
                check_eq("t1_ack", 32'(t1_if.ack), 32'(g1));
                check_eq("t0_rvalid", 32'(t0_if.read_valid), 32'(rv0_e));
                check_eq("t1_rvalid", 32'(t1_if.read_valid), 32'(rv1_e));
                if (rv0_e) begin
                    if (q0.size() == 0) check_eq("t0_q_underflow", 32'(q0.size()), 32'd1);
                    else begin
                        v = q0.pop_front();
                        check_eq("t0_rdata", t0_if.read_data, v);
                        last_rd0 = t0_if.read_data;
                    end
                end
                if (rv1_e) begin
                    if (q1.size() == 0) check_eq("t1_q_underflow", 32'(q1.size()), 32'd1);
                    else begin
                        v = q1.pop_front();
                        check_eq("t1_rdata", t1_if.read_data, v);
                    end
                end
                rv0_e = g0 && t0_if.read_en;
                rv1_e = g1 && t1_if.read_en;
                if (g0) begin
                    model_access(t0_if.write_en, t0_if.addr, t0_if.byte_en, t0_if.write_data, v);
                    if (t0_if.read_en) q0.push_back(v);
                    lg = 1'b0;
                end
                if (g1) begin
                    model_access(t1_if.write_en, t1_if.addr, t1_if.byte_en, t1_if.write_data, v);
                    if (t1_if.read_en) q1.push_back(v);
                    lg = 1'b1;
                end
            end
        end
    end

    task automatic set_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        if (p == 0) begin
            t0_if.read_en = rd; t0_if.write_en = wr; t0_if.addr = a;
            t0_if.byte_en = be; t0_if.write_data = wd;
        end else begin
            t1_if.read_en = rd; t1_if.write_en = wr; t1_if.addr = a;
            t1_if.byte_en = be; t1_if.write_data = wd;
        end
    endtask

    // Issue one request and hold it until acked. Return just after the consuming edge.
    task automatic do_req(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        set_port(p, rd, wr, a, be, wd);
        @(negedge clock);
        while (!(p == 0 ? t0_if.ack : t1_if.ack) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq("ack_wait_bounded", 32'(n < 200), 32'd1);
        @(posedge clock); #1;
        set_port(p, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    endtask

    // Release reset with a t0 request pending, and measure how long until the first ack.
    task automatic release_and_clear();
        int n = 0;
`ifdef CLUSTERV_SRAM_INIT_CLEAR_EN
        set_port(0, 1'b1, 1'b0, 10'd63, 4'h0, 32'h0);
`else
        set_port(0, 1'b0, 1'b1, 10'd63, 4'hF, 32'h0);
`endif
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        while (!t0_if.ack && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_eq("clear_latency", 32'(n), 32'(CLR_CYC));
        check_eq("ready_at_first_ack", 32'(ready), 32'd1);
        @(posedge clock); #1;
        set_port(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
`ifdef CLUSTERV_SRAM_INIT_CLEAR_EN
`else
        do_req(0, 1'b1, 1'b0, 10'd63, 4'h0, 32'h0);
`endif
    endtask

    initial begin
        set_port(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_ready", 32'(ready), 32'(RST_RDY));
        check_eq("rst_t0_rvalid", 32'(t0_if.read_valid), 32'd0);
        check_eq("rst_t0_rdata", t0_if.read_data, 32'h0);
        check_eq("rst_t1_rdata", t1_if.read_data, 32'h0);

        release_and_clear();

        // Contention: the last grant goes to port 1, so port 0 must win first.
        do_req(1, 1'b0, 1'b1, 10'd20, 4'hF, 32'h0BADF00D);
        do_req(1, 1'b0, 1'b1, 10'd21, 4'hF, 32'h5EED5EED);
        set_port(0, 1'b1, 1'b0, 10'd20, 4'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 10'd21, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_eq("cont_ack0", 32'(t0_if.ack), 32'(i % 2 == 0));
            check_eq("cont_ack1", 32'(t1_if.ack), 32'(i % 2 == 1));
        end
        @(posedge clock); #1;
        set_port(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, '0, 4'h0, 32'h0);

        // Byte lanes.
        do_req(0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hAABBCCDD);
        do_req(0, 1'b0, 1'b1, 10'd5, 4'h5, 32'h11223344);
        do_req(0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
        @(negedge clock);
        check_eq("lanes_const", last_rd0, 32'hAA22CC44);

        // Cross-port RAW: t1 writes in C, and t0 reads in C+1.
        do_req(1, 1'b0, 1'b1, 10'd10, 4'hF, 32'hDEADBEEF);
        do_req(0, 1'b1, 1'b0, 10'd10, 4'h0, 32'h0);

        // Out of range: the write is dropped and the read returns 0.
        do_req(0, 1'b0, 1'b1, 10'd36, 4'hF, 32'h36363636);
        do_req(0, 1'b0, 1'b1, 10'd100, 4'hF, 32'h12345678);
        do_req(0, 1'b1, 1'b0, 10'd100, 4'h0, 32'h0);
        do_req(0, 1'b1, 1'b0, 10'd36, 4'h0, 32'h0);

        // Combined read+write returns the merged word. A zero byte_en write is a no-op.
        do_req(1, 1'b0, 1'b1, 10'd7, 4'hF, 32'h01020304);
        do_req(1, 1'b1, 1'b1, 10'd7, 4'h3, 32'hFFFFA5A5);
        do_req(1, 1'b0, 1'b1, 10'd7, 4'h0, 32'h99999999);
        do_req(1, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);

        // Uncontested back-to-back: acked every cycle.
        set_port(1, 1'b1, 1'b0, 10'd20, 4'h0, 32'h0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        set_port(1, 1'b0, 1'b0, '0, 4'h0, 32'h0);

        // Mid-operation reset while a t0 read_valid is in flight.
        do_req(0, 1'b1, 1'b0, 10'd36, 4'h0, 32'h0);
        check_eq("rvalid_before_reset", 32'(t0_if.read_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", 32'(t0_if.read_valid), 32'd0);
        check_eq("mid_rst_ack", 32'(t0_if.ack), 32'd0);
        check_eq("mid_rst_rdata", t0_if.read_data, 32'h0);
        check_eq("mid_rst_ready", 32'(ready), 32'(RST_RDY));
        repeat (2) @(posedge clock);
        release_and_clear();
`ifdef CLUSTERV_SRAM_INIT_CLEAR_EN
        do_req(0, 1'b1, 1'b0, 10'd36, 4'h0, 32'h0);
`else
        do_req(0, 1'b1, 1'b1, 10'd36, 4'hF, 32'h76543210);
`endif

        repeat (4) @(negedge clock);
        check_eq("t0_queue_drained", 32'(q0.size()), 32'd0);
        check_eq("t1_queue_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
